adc_channel_scanner: RTL and testbench

ADC_CHANNEL_SCANNER -- requirements
Module: adc_channel_scanner

---
 rtl/adc_pkg.sv | 39 +++
 rtl/adc_sync_2ff.sv | 22 ++
 rtl/adc_channel_scanner.sv | 148 ++++++++++++++
 tb/tb_adc_channel_scanner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and channel-walk helpers for the ADC channel scanner.
package adc_pkg;

    localparam int NUM_CHAN = 8;
    localparam int SAMPLE_W = 12;

    typedef logic [2:0]          chan_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_EMIT
    } state_t;

    // Lowest enabled channel; 0 when no channel is enabled.
    function automatic chan_t first_chan(input logic [NUM_CHAN-1:0] mask);
        chan_t r;
        r = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i]) r = chan_t'(i);
        end
        return r;
    endfunction

    // Next enabled channel above cur, wrapping 7->0; cur itself when it is the only one.
    function automatic chan_t next_chan(input logic [NUM_CHAN-1:0] mask, input chan_t cur);
        chan_t r;
        chan_t c;
        r = cur;
        for (int i = NUM_CHAN - 1; i >= 1; i--) begin
            c = cur + chan_t'(i);
            if (mask[c]) r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sync_2ff.sv
// Two-flop synchronizer bringing the capture-stage ready flag into the clk domain.
module adc_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_channel_scanner.sv
// Scans enabled ADC channels, optionally averages 2^AVG_LOG2 samples per channel
// (macro ADC_SCAN_AVG_EN), and hands results downstream over valid/ready.
module adc_channel_scanner
    import adc_pkg::*;
#(
    parameter logic [NUM_CHAN-1:0] CHAN_MASK     = 8'hFF,
    parameter int                  AVG_LOG2      = 2,
    parameter bit                  DISCARD_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_ready,
    input  logic [11:0] d_signal,
    output logic        adc_ack,
    output logic [2:0]  address,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_chan,
    output logic [11:0] out_data,
    output logic        busy
);

    if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("AVG_LOG2 must be in 0..4");
    end

`ifdef ADC_SCAN_AVG_EN
    localparam int EFF_LOG2 = AVG_LOG2;
`else
    localparam int EFF_LOG2 = 0;
`endif
    localparam int              CNT_W    = EFF_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << EFF_LOG2);

    state_t           state;
    state_t           next_state;
    logic             rdy_s;
    logic             rdy_q;
    logic             ready_event;
    logic             discard_pending;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             leave_ack;
    logic             xfer;
    logic             take_sample;
    logic             clear_acc;
    sample_t          result;

    adc_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (adc_ready),
        .q   (rdy_s)
    );

    assign ready_event = rdy_s && !rdy_q;
    assign full        = (count == CNT_FULL);
    assign leave_ack   = (state == S_ACK) && !rdy_s;
    assign xfer        = (state == S_EMIT) && out_valid && out_ready;
    assign take_sample = (state == S_WAIT) && enable && ready_event && !discard_pending;
    // A partial accumulation is abandoned whenever scanning stops short of an emit.
    assign clear_acc   = ((state == S_WAIT) && !enable) || (leave_ack && !full && !enable) || xfer;

    assign adc_ack = (state == S_ACK);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (enable) next_state = S_WAIT;
            S_WAIT: begin
                if (!enable)          next_state = S_IDLE;
                else if (ready_event) next_state = S_ACK;
            end
            S_ACK: begin
                if (!rdy_s) begin
                    if (full)         next_state = S_EMIT;
                    else if (!enable) next_state = S_IDLE;
                    else              next_state = S_WAIT;
                end
            end
            S_EMIT: if (xfer) next_state = enable ? S_WAIT : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

`ifdef ADC_SCAN_AVG_EN
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              acc <= '0;
        else if (clear_acc)   acc <= '0;
        else if (take_sample) acc <= acc + ACC_W'(d_signal);
    end

    assign result = sample_t'(acc >> AVG_LOG2);
`else
    sample_t sample_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sample_q <= '0;
        else if (take_sample) sample_q <= d_signal;
    end

    assign result = sample_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q           <= 1'b0;
            discard_pending <= 1'b0;
            count           <= '0;
            address         <= first_chan(CHAN_MASK);
            out_valid       <= 1'b0;
            out_chan        <= '0;
            out_data        <= '0;
        end else begin
            rdy_q <= rdy_s;

            if (clear_acc)        count <= '0;
            else if (take_sample) count <= count + CNT_W'(1);

            if (((state == S_IDLE) && enable) || xfer)
                discard_pending <= DISCARD_FIRST;
            else if ((state == S_WAIT) && enable && ready_event)
                discard_pending <= 1'b0;

            if (leave_ack && full) begin
                out_valid <= 1'b1;
                out_chan  <= address;
                out_data  <= result;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            if (xfer) address <= next_chan(CHAN_MASK, address);
        end
    end

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Directed bench for adc_channel_scanner; expectations follow ADC_SCAN_AVG_EN when defined.
module tb_adc_channel_scanner;

`ifdef ADC_SCAN_AVG_EN
    localparam int          N_AVG     = 4;
    localparam logic [11:0] EXP_FIRST = 12'd250;
    localparam int          DATA_OFS  = 2;
`else
    localparam int          N_AVG     = 1;
    localparam logic [11:0] EXP_FIRST = 12'd100;
    localparam int          DATA_OFS  = 1;
`endif
    localparam int SEL_A = 0;
    localparam int SEL_M = 1;
    localparam int SEL_N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        adc_ready;
    logic        out_ready;
    logic [11:0] d_signal;

    logic        a_ack, a_valid, a_busy;
    logic [2:0]  a_addr, a_chan;
    logic [11:0] a_data;
    logic        m_ack, m_valid, m_busy;
    logic [2:0]  m_addr, m_chan;
    logic [11:0] m_data;
    logic        n_ack, n_valid, n_busy;
    logic [2:0]  n_addr, n_chan;
    logic [11:0] n_data;
    logic [2:0]  acks;

    int checks   = 0;
    int errors   = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    assign acks = {n_ack, m_ack, a_ack};

    adc_channel_scanner u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .adc_ready(adc_ready), .d_signal(d_signal),
        .adc_ack(a_ack), .address(a_addr), .out_valid(a_valid), .out_ready(out_ready),
        .out_chan(a_chan), .out_data(a_data), .busy(a_busy)
    );

    adc_channel_scanner #(.CHAN_MASK(8'b1000_0100)) u_dut_m (
        .clk(clk), .rst(rst), .enable(enable), .adc_ready(adc_ready), .d_signal(d_signal),
        .adc_ack(m_ack), .address(m_addr), .out_valid(m_valid), .out_ready(out_ready),
        .out_chan(m_chan), .out_data(m_data), .busy(m_busy)
    );

    adc_channel_scanner #(.DISCARD_FIRST(1'b0)) u_dut_n (
        .clk(clk), .rst(rst), .enable(enable), .adc_ready(adc_ready), .d_signal(d_signal),
        .adc_ack(n_ack), .address(n_addr), .out_valid(n_valid), .out_ready(out_ready),
        .out_chan(n_chan), .out_data(n_data), .busy(n_busy)
    );

    always @(posedge clk) begin
        if (a_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_ack(input int sel, input logic level, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (acks[sel] === level) break;
            @(negedge clk);
        end
        check(tag, 32'(acks[sel]), 32'(level));
    endtask

    // Capture-stage model: present a result, drop ready once it is acknowledged.
    task automatic send_sample(input int sel, input logic [11:0] v);
        d_signal  = v;
        adc_ready = 1'b1;
        wait_ack(sel, 1'b1, "ack_rise");
        adc_ready = 1'b0;
        wait_ack(sel, 1'b0, "ack_fall");
        @(negedge clk);
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        enable    = 1'b0;
        adc_ready = 1'b0;
        out_ready = 1'b0;
        d_signal  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int x0;
        int seq [4] = '{2, 7, 2, 7};
        rst       = 1'b1;
        enable    = 1'b0;
        adc_ready = 1'b0;
        out_ready = 1'b0;
        d_signal  = '0;

        // Reset state, one averaged result on ch0, then back-pressure.
        do_reset();
        check("rst_busy",  a_busy,  0);
        check("rst_ack",   a_ack,   0);
        check("rst_valid", a_valid, 0);
        check("rst_data",  a_data,  0);
        check("rst_chan",  a_chan,  0);
        check("rst_addr",  a_addr,  0);
        check("rst_addr_m", m_addr, 2);
        enable = 1'b1;
        @(negedge clk);
        check("busy_run", a_busy, 1);
        send_sample(SEL_A, 12'd100);
        check("discard_no_out", a_valid, 0);
`ifdef ADC_SCAN_AVG_EN
        for (int s = 0; s < 3; s++) begin
            send_sample(SEL_A, 12'd200);
            check("acc_no_out", a_valid, 0);
        end
        send_sample(SEL_A, 12'd400);
`else
        send_sample(SEL_A, 12'd100);
`endif
        check("emit_valid", a_valid, 1);
        check("emit_chan",  a_chan,  0);
        check("emit_data",  a_data,  EXP_FIRST);
        check("emit_addr",  a_addr,  0);

        x0 = xfer_cnt;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                d_signal  = 12'h123;
                adc_ready = 1'b1;
            end
            if (c == 30) adc_ready = 1'b0;
            @(negedge clk);
            check("stall", 32'({a_valid, a_ack, a_data}), 32'({1'b1, 1'b0, EXP_FIRST}));
        end
        pulse_ready();
        check("xfer_valid", a_valid, 0);
        check("xfer_addr",  a_addr,  1);
        repeat (5) @(negedge clk);
        check("xfer_once", 32'(xfer_cnt - x0), 1);

        // adc_ready held high: a single sample, ack held until the synced flag drops.
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        check("n_busy", n_busy, 1);
        d_signal  = 12'hFFF;
        adc_ready = 1'b1;
        wait_ack(SEL_N, 1'b1, "hold_ack_rise");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_ack", n_ack, 1);
        end
        adc_ready = 1'b0;
        @(negedge clk);
        check("ack_until_rdy_low", n_ack, 1);
        wait_ack(SEL_N, 1'b0, "hold_ack_fall");
`ifdef ADC_SCAN_AVG_EN
        check("one_of_four", n_valid, 0);
        for (int s = 0; s < 3; s++) send_sample(SEL_N, 12'd0);
        check("hold_valid", n_valid, 1);
        check("hold_data",  n_data,  12'h3FF);
`else
        check("hold_valid", n_valid, 1);
        check("hold_data",  n_data,  12'hFFF);
`endif
        check("hold_chan", n_chan, 0);
        pulse_ready();
        check("hold_addr", n_addr, 1);
        repeat (3) @(negedge clk);
        check("no_second_out", n_valid, 0);

        // Sparse mask walks 2,7,2,7.
        do_reset();
        check("m_addr_rst", m_addr, 2);
        enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("m_addr_seq", m_addr, seq[k]);
            for (int s = 0; s <= N_AVG; s++) send_sample(SEL_M, 12'(16 * k + s));
            check("m_emit_valid", m_valid, 1);
            check("m_emit_chan",  m_chan,  seq[k]);
            check("m_emit_data",  m_data,  16 * k + DATA_OFS);
            pulse_ready();
        end
        check("m_addr_wrap", m_addr, 2);

        // Disable while waiting, then reset during an acknowledge.
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_on_disable", m_busy, 0);
        enable = 1'b1;
        @(negedge clk);
        d_signal  = 12'd5;
        adc_ready = 1'b1;
        wait_ack(SEL_M, 1'b1, "pre_rst_ack");
        rst = 1'b1;
        #1;
        check("rst_async_ack",   m_ack,   0);
        check("rst_async_addr",  m_addr,  2);
        check("rst_async_valid", m_valid, 0);
        check("rst_async_busy",  m_busy,  0);
        check("rst_async_ack_a", a_ack,   0);
        adc_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
